// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and arithmetic helpers for the multiply/divide sequencer.
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // Returns {remainder, quotient}. Division runs on magnitudes so the
  // most-negative / -1 case wraps to 0x80000000 with remainder 0.
  function automatic logic [63:0] div_res(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models latency with a down-counter
// and raises the pipeline stall for dependent D-stage instructions.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi_pend;
  logic [31:0] r_lo_pend;
  logic        r_div0;

  logic        w_is_md;
  logic [63:0] w_res;

  assign w_is_md = start & (md_op <= MD_DIVU);
  assign stall   = md_use_d & (busy | w_is_md);

  always_comb begin
    w_res = '0;
    case (md_op)
      MD_MULT:  w_res = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      MD_MULTU: w_res = {32'b0, src_a} * {32'b0, src_b};
      MD_DIV:   w_res = div_res(src_a, src_b, 1'b1);
      MD_DIVU:  w_res = div_res(src_a, src_b, 1'b0);
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi_pend <= '0;
      r_lo_pend <= '0;
      r_div0    <= 1'b0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_md) begin
            r_hi_pend <= w_res[63:32];
            r_lo_pend <= w_res[31:0];
            r_div0    <= md_op[1] & (src_b == '0);
            r_cnt     <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy      <= 1'b1;
            r_state   <= ST_BUSY;
          end else if (start && md_op == MD_MTHI) begin
            hi <= src_a;
          end else if (start && md_op == MD_MTLO) begin
            lo <= src_a;
          end
        end
        ST_BUSY: begin
          // start is ignored here; the stall keeps the pipeline off us
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_div0) begin
              hi <= r_hi_pend;
              lo <= r_lo_pend;
            end
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic, latency, moves, stall and reset abort.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        md_use_d;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .md_use_d(md_use_d),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
  endtask

  // counts samples with busy high, bounded so a stuck busy still terminates
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, n2, ns;
    reset = 1'b1; start = 1'b0; md_op = 3'd7; src_a = '0; src_b = '0; md_use_d = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_cycles", n, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_busy", busy, 0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_cycles", n, 5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, 10);
    chk("div0_lo", lo, 32'd14);
    chk("div0_hi", hi, 32'd2);

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd14);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("nop_busy", busy, 0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'hCAFE_F00D);

    // stall with a dependent D-stage instruction
    md_use_d = 1'b1;
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    #1 chk("stall_start", stall, 1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall) ns++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", ns, 5);
    chk("stall_after", stall, 0);
    chk("mult2_lo", lo, 32'd12);
    chk("mult2_hi", hi, 32'd0);

    md_use_d = 1'b0;
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    #1 chk("nostall_start", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall) ns++;
      @(posedge clk); #1;
    end
    chk("nostall_cycles", ns, 0);

    // start while busy must not disturb the in-flight result
    issue(3'd1, 32'd6, 32'd7);
    n = busy ? 1 : 0;
    start = 1'b1; md_op = 3'd4; src_a = 32'hDEAD; src_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    wait_idle(n2);
    chk("ign_cycles", n + n2, 5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);

    // reset in cycle 3 of a DIV aborts without commit
    issue(3'd2, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_post_busy", busy, 0);
    chk("abort_post_hi", hi, 0);
    chk("abort_post_lo", lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the multiply/divide unit in the execute stage. It owns the HI/LO registers.
- It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse and holds the unit busy for a fixed latency. It generates the pipeline stall for any later HI/LO-using instruction.
- It sits beside the ALU and is driven by decoder outputs carried in the E-stage pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MDU command; sampled on the rising edge
- md_op  input  3  command: mdMult=0, mdMultu=1, mdDiv=2, mdDivu=3, mdMthi=4, mdMtlo=5; 6 and 7 are no-ops
- src_a  input  32  rs operand
- src_b  input  32  rt operand
- md_use_d  input  1  D-stage instruction uses the MDU (any of the six commands, MFHI or MFLO)
- busy  output  1  operation in flight
- stall  output  1  freeze PC and the F/D registers and bubble the E stage
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (asynchronous) clears:
  - state to IDLE
  - counter to 0
  - busy, hi and lo to 0
  - pending result registers to 0
- Reset during BUSY aborts the operation. Nothing is committed and hi/lo read 0.
- States: IDLE and BUSY.
- IDLE with start=1 and md_op in {0..3}:
  - On the edge, latch the 64-bit result into hi_pend/lo_pend.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- IDLE with start=1 and md_op=4 or 5:
  - src_a is written to hi (op 4) or lo (op 5) on that edge.
  - No BUSY state is entered; the new value is visible the next cycle.
- IDLE with start=1 and md_op=6 or 7: ignored.
- BUSY: the counter decrements on every edge.
  - On the edge where the counter equals 1: hi<=hi_pend, lo<=lo_pend, busy<=0, state goes to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. New hi/lo appear in the first cycle with busy=0.
- start while BUSY is ignored. The stall keeps this from happening in normal operation; the bench checks that hi/lo are not corrupted.
- Arithmetic:
  - MULT: signed 32x32 -> 64 bits, hi = upper word, lo = lower word.
  - MULTU: the same, unsigned.
  - DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (src_b=0): the command still runs the full DIV_CYCLES, but hi/lo are left unchanged at commit.
- stall = md_use_d & (busy | (start & md_op<=3)). It is combinational and has no dependence on the counter value.
- hi and lo are registered outputs with no bypass; an MFHI/MFLO reads them through the stall.

Decomposition:
- The md_op encodings (mdMult..mdMtlo) go into define.v next to the alu* and sl* codes. The decoder then grows an MdOp field and an MdStart bit.
- No sub-module. The multiply and divide are behavioural operators registered into hi_pend/lo_pend; the latency is modelled by the counter.

Test Plan:
- Signed multiply: reset, then MULT with src_a=0xFFFFFFFE (-2), src_b=3.
  - busy is high for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, and busy=0.
- Unsigned multiply: MULTU with 0xFFFFFFFF x 0xFFFFFFFF.
  - After 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide:
  - DIV -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
  - DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Unsigned divide:
  - DIVU 100/7 gives lo=14, hi=2.
  - DIV with src_b=0 keeps the prior hi/lo, and busy still lasts 10 cycles.
- Move and stall:
  - MTHI 0x12345678 gives hi=0x12345678 the next cycle with busy never high.
  - MULT followed by md_use_d=1 gives stall=1 in the start cycle and in all 5 busy cycles, then 0.
  - With md_use_d=0, stall stays 0 throughout.
- Reset and ignored start:
  - Assert reset in cycle 3 of a DIV: busy and hi/lo drop to 0 immediately, and no commit follows.
  - A start pulse while busy leaves the in-flight result intact.
